// File: rtl/risc16_cpu.sv
// risc16_cpu: single-cycle RiSC-16 core, 8 GPRs, one instruction retired per clock.
// Optional HALT (JALR with nonzero imm7) is built when RISC16_HALT_EN is defined.
module risc16_cpu #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  output logic [15:0] instr_addr,
  output logic        we_dmem,
  output logic [15:0] data_addr,
  output logic [15:0] data_in,
  input  logic [15:0] data_out
);

  logic [15:0] pc;
  logic [15:0] gpr [8];

  logic [2:0]  op, ra, rb, rc;
  logic [15:0] simm, limm;
  logic [15:0] ra_val, rb_val, rc_val;
  logic [15:0] pc_inc;

  logic is_add, is_addi, is_nand, is_lui;
  logic is_sw, is_lw, is_beq, is_jalr;

  logic        halt_now;
  logic        wr_en;
  logic [15:0] wr_val;
  logic [15:0] next_pc;

  assign op   = instr[15:13];
  assign ra   = instr[12:10];
  assign rb   = instr[9:7];
  assign rc   = instr[2:0];
  assign simm = {{9{instr[6]}}, instr[6:0]};
  assign limm = {instr[9:0], 6'b0};

  // r0 is hardwired to zero on the read side
  assign ra_val = (ra == 3'd0) ? 16'h0000 : gpr[ra];
  assign rb_val = (rb == 3'd0) ? 16'h0000 : gpr[rb];
  assign rc_val = (rc == 3'd0) ? 16'h0000 : gpr[rc];

  assign pc_inc = pc + 16'd1;

  assign is_add  = (op == 3'd0);
  assign is_addi = (op == 3'd1);
  assign is_nand = (op == 3'd2);
  assign is_lui  = (op == 3'd3);
  assign is_sw   = (op == 3'd4);
  assign is_lw   = (op == 3'd5);
  assign is_beq  = (op == 3'd6);
  assign is_jalr = (op == 3'd7);

`ifdef RISC16_HALT_EN
  logic halted;

  assign halt_now = halted | (is_jalr & (|instr[6:0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted <= 1'b0;
    end else begin
      halted <= halt_now;
    end
  end
`else
  assign halt_now = 1'b0;
`endif

  assign instr_addr = pc;
  assign data_addr  = rb_val + simm;
  assign data_in    = ra_val;
  assign we_dmem    = is_sw & ~halt_now & reset;

  always_comb begin
    wr_en   = 1'b0;
    wr_val  = 16'h0000;
    next_pc = pc_inc;
    unique case (1'b1)
      is_add: begin
        wr_en  = 1'b1;
        wr_val = rb_val + rc_val;
      end
      is_addi: begin
        wr_en  = 1'b1;
        wr_val = rb_val + simm;
      end
      is_nand: begin
        wr_en  = 1'b1;
        wr_val = ~(rb_val & rc_val);
      end
      is_lui: begin
        wr_en  = 1'b1;
        wr_val = limm;
      end
      is_sw: begin
        wr_en = 1'b0;
      end
      is_lw: begin
        wr_en  = 1'b1;
        wr_val = data_out;
      end
      is_beq: begin
        if (ra_val == rb_val) next_pc = pc_inc + simm;
      end
      is_jalr: begin
        wr_en   = 1'b1;
        wr_val  = pc_inc;
        next_pc = rb_val;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
    if (halt_now) begin
      wr_en   = 1'b0;
      next_pc = pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 8; i++) gpr[i] <= 16'h0000;
    end else begin
      pc <= next_pc;
      if (wr_en && ra != 3'd0) gpr[ra] <= wr_val;
    end
  end

endmodule

// File: tb/tb_risc16_cpu.sv
// tb_risc16_cpu: vector table, directed reset/halt sequences and an
// ISA-level reference model run over random memory contents.
module tb_risc16_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        we_dmem;
  logic [15:0] data_addr;
  logic [15:0] data_in;
  logic [15:0] data_out;

  logic [15:0] mem [65536];

  int errors = 0;
  int checks = 0;

  risc16_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .instr_addr (instr_addr),
    .we_dmem    (we_dmem),
    .data_addr  (data_addr),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  assign instr    = mem[instr_addr];
  assign data_out = mem[data_addr];

  always @(posedge clk) begin
    if (we_dmem) mem[data_addr] <= data_in;
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rri(input int op, input int a,
                                      input int b, input int imm);
    return {op[2:0], a[2:0], b[2:0], imm[6:0]};
  endfunction

  function automatic logic [15:0] rrr(input int op, input int a,
                                      input int b, input int c);
    return {op[2:0], a[2:0], b[2:0], 4'b0000, c[2:0]};
  endfunction

  function automatic logic [15:0] lui(input int a, input int imm);
    return {3'd3, a[2:0], imm[9:0]};
  endfunction

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
    logic        we;
    logic        ca;
    logic [15:0] addr;
    logic [15:0] din;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] ins, input logic [15:0] pc,
                              input logic we, input logic ca,
                              input logic [15:0] addr, input logic [15:0] din);
    vec_t v;
    v.ins = ins; v.pc = pc; v.we = we; v.ca = ca; v.addr = addr; v.din = din;
    return v;
  endfunction

  vec_t tv [20];

  // reference model state
  logic [15:0] mr [8];
  logic [15:0] mpc;
  logic        mhalt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
    mpc   = 16'h0000;
    mhalt = 1'b0;
  endtask

  task automatic model_cycle();
    logic [15:0] w, s, av, bv, cv, res;
    logic [2:0]  o, a, b, c;
    logic        hlt, wr;
    logic [15:0] npc;
    w  = mem[mpc];
    o  = w[15:13]; a = w[12:10]; b = w[9:7]; c = w[2:0];
    s  = {{9{w[6]}}, w[6:0]};
    av = mr[a]; bv = mr[b]; cv = mr[c];
    hlt = mhalt;
`ifdef RISC16_HALT_EN
    if (o == 3'd7 && w[6:0] != 7'd0) hlt = 1'b1;
`endif
    chk("rnd_pc", instr_addr, mpc);
    chk("rnd_we", {15'd0, we_dmem}, {15'd0, (o == 3'd4) && !hlt});
    if (o == 3'd4 || o == 3'd5) chk("rnd_addr", data_addr, bv + s);
    if (o == 3'd4) chk("rnd_din", data_in, av);
    wr  = 1'b1;
    res = 16'h0000;
    npc = mpc + 16'd1;
    case (o)
      3'd0: res = bv + cv;
      3'd1: res = bv + s;
      3'd2: res = ~(bv & cv);
      3'd3: res = w[9:0] * 16'd64;
      3'd4: wr = 1'b0;
      3'd5: res = mem[bv + s];
      3'd6: begin
        wr = 1'b0;
        if (av == bv) npc = mpc + 16'd1 + s;
      end
      default: begin
        res = mpc + 16'd1;
        npc = bv;
      end
    endcase
    if (hlt) begin
      mhalt = 1'b1;
    end else begin
      if (wr && a != 3'd0) mr[a] = res;
      mpc = npc;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_mem();

    tv[0]  = mk(rri(1, 1, 0, 5),    16'd0,  0, 0, 16'h0000, 16'h0000);
    tv[1]  = mk(rri(1, 2, 0, -3),   16'd1,  0, 1, 16'hFFFD, 16'h0000);
    tv[2]  = mk(rrr(0, 3, 1, 2),    16'd2,  0, 0, 16'h0000, 16'h0000);
    tv[3]  = mk(rrr(2, 4, 1, 1),    16'd3,  0, 0, 16'h0000, 16'h0000);
    tv[4]  = mk(rri(4, 3, 0, 20),   16'd4,  1, 1, 16'd20,   16'h0002);
    tv[5]  = mk(rri(4, 4, 0, 21),   16'd5,  1, 1, 16'd21,   16'hFFFA);
    tv[6]  = mk(lui(1, 'h3FF),      16'd6,  0, 0, 16'h0000, 16'h0000);
    tv[7]  = mk(rri(1, 1, 1, 'h3F), 16'd7,  0, 0, 16'h0000, 16'h0000);
    tv[8]  = mk(rri(4, 1, 0, 20),   16'd8,  1, 1, 16'd20,   16'hFFFF);
    tv[9]  = mk(rri(5, 2, 0, 20),   16'd9,  0, 1, 16'd20,   16'h0000);
    tv[10] = mk(rri(4, 2, 0, 22),   16'd10, 1, 1, 16'd22,   16'hFFFF);
    tv[11] = mk(rri(1, 0, 0, 9),    16'd11, 0, 0, 16'h0000, 16'h0000);
    tv[12] = mk(rri(4, 0, 0, 23),   16'd12, 1, 1, 16'd23,   16'h0000);
    tv[13] = mk(rri(1, 5, 0, 48),   16'd13, 0, 0, 16'h0000, 16'h0000);
    tv[14] = mk(rri(7, 6, 5, 0),    16'd14, 0, 0, 16'h0000, 16'h0000);
    tv[15] = mk(rri(4, 6, 0, 24),   16'd48, 1, 1, 16'd24,   16'd15);
    tv[16] = mk(rri(6, 1, 3, 2),    16'd49, 0, 0, 16'h0000, 16'h0000);
    tv[17] = mk(rri(6, 1, 2, -1),   16'd50, 0, 0, 16'h0000, 16'h0000);
    tv[18] = mk(rri(6, 1, 2, -1),   16'd50, 0, 0, 16'h0000, 16'h0000);
    tv[19] = mk(rri(6, 1, 2, -1),   16'd50, 0, 0, 16'h0000, 16'h0000);

    // a store at RESET_PC must stay suppressed while reset is held
    mem[0] = rri(4, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("rst_pc0", instr_addr, 16'h0000);
    chk("rst_we0", {15'd0, we_dmem}, 16'h0000);
    @(negedge clk);
    #1;
    chk("rst_pc1", instr_addr, 16'h0000);
    chk("rst_we1", {15'd0, we_dmem}, 16'h0000);
    chk("rst_nowr", mem[1], 16'h0000);

    for (int i = 0; i < 20; i++) mem[tv[i].pc] = tv[i].ins;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("tv%0d_pc", i), instr_addr, tv[i].pc);
      chk($sformatf("tv%0d_we", i), {15'd0, we_dmem}, {15'd0, tv[i].we});
      if (tv[i].ca) chk($sformatf("tv%0d_addr", i), data_addr, tv[i].addr);
      if (tv[i].we) chk($sformatf("tv%0d_din", i), data_in, tv[i].din);
      step();
    end
    chk("mem20", mem[20], 16'hFFFF);
    chk("mem21", mem[21], 16'hFFFA);

    // reset asserted mid-instruction abandons the pending ADDI
    reset = 1'b0;
    clear_mem();
    mem[0] = rri(4, 1, 0, 30);
    mem[1] = rri(1, 1, 0, 9);
    mem[2] = rri(7, 0, 0, 0);
    release_reset();
    chk("mid_pc0", instr_addr, 16'd0);
    chk("mid_din0", data_in, 16'h0000);
    step();
    chk("mid_pc1", instr_addr, 16'd1);
    reset = 1'b0;
    #1;
    chk("mid_async_pc", instr_addr, 16'd0);
    chk("mid_async_we", {15'd0, we_dmem}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_pc_rel", instr_addr, 16'd0);
    chk("mid_din_rel", data_in, 16'h0000);
    step();
    step();
    chk("mid_pc2", instr_addr, 16'd2);
    step();
    chk("mid_loop_pc", instr_addr, 16'd0);
    chk("mid_din9", data_in, 16'd9);

    // JALR with nonzero imm7: HALT when enabled, plain JALR otherwise
    reset = 1'b0;
    clear_mem();
    mem[0]  = rri(1, 1, 0, 8);
    mem[1]  = rri(1, 4, 0, 12);
    mem[2]  = rri(7, 0, 1, 0);
    mem[8]  = rri(7, 3, 4, 5);
    mem[12] = rri(4, 3, 0, 40);
    release_reset();
    step();
    step();
    chk("jr_pc2", instr_addr, 16'd2);
    step();
    chk("jr_pc8", instr_addr, 16'd8);
`ifdef RISC16_HALT_EN
    for (int i = 0; i < 100; i++) begin
      step();
      chk("halt_pc", instr_addr, 16'd8);
      chk("halt_we", {15'd0, we_dmem}, 16'h0000);
    end
    chk("halt_mem40", mem[40], 16'h0000);
`else
    step();
    chk("jalr_pc12", instr_addr, 16'd12);
    chk("jalr_we", {15'd0, we_dmem}, 16'h0001);
    chk("jalr_link", data_in, 16'd9);
`endif

    // random programs against the ISA model, with async resets sprinkled in
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
`ifdef RISC16_HALT_EN
      if (mem[i][15:13] == 3'd7 && $urandom_range(0, 7) != 0)
        mem[i][6:0] = 7'd0;
`endif
    end
    model_reset();
    release_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc % 400 == 399) begin
        reset = 1'b0;
        #1;
        chk("rnd_rst_pc", instr_addr, 16'h0000);
        chk("rnd_rst_we", {15'd0, we_dmem}, 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
      end else begin
        model_cycle();
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
